// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, frame-format encodings and helper functions.
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STOP_1   = 1'b0;
    localparam logic STOP_2   = 1'b1;
    function automatic int clog2w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: received-word valid/ready stream with error and event flags.
interface uart_rx_cfg_if #(parameter int MAX_DATAWIDTH = 8);
    logic [MAX_DATAWIDTH-1:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic parity_error;
    logic framing_error;
    logic overrun_error;
    logic break_detect;
    modport master(output rx_data, rx_valid, parity_error, framing_error, overrun_error, break_detect,
                   input rx_ready);
    modport slave(input rx_data, rx_valid, parity_error, framing_error, overrun_error, break_detect,
                  output rx_ready);
endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversampling tick, one pulse every div+1 clock cycles.
module uart_os_tick #(
    parameter int DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    // >= lets a shrinking divisor take effect at once instead of waiting for wrap-around
    always_comb begin
        tick  = cnt_q >= div;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime frame format, majority-of-3 sampling,
// valid/ready output register and parity/framing/overrun/break reporting.
module uart_rx_cfg import uart_pkg::*; #(
    parameter int MAX_DATAWIDTH = 8,
    parameter int OVERSAMPLING  = 16,
    parameter int DIV_WIDTH     = 12,
    localparam int DBW = clog2w(MAX_DATAWIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [DBW-1:0]       data_bits,
    input  logic                 parity_enable,
    input  logic                 parity_type,
    input  logic                 stop_bits,
    input  logic                 rx,
    uart_rx_cfg_if.master        rxo,
    output logic                 busy
);
    localparam int SCW = clog2w(OVERSAMPLING);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLING - 1);
    localparam logic [SCW-1:0] SC_M    = SCW'(OVERSAMPLING / 2);
    localparam logic [SCW-1:0] SC_LO   = SC_M - 1'b1;
    localparam logic [SCW-1:0] SC_HI   = SC_M + 1'b1;
    localparam logic [DBW-1:0] NB_MIN  = DBW'(5);
    localparam logic [DBW-1:0] NB_MAX  = DBW'(MAX_DATAWIDTH);

    logic tick;
    uart_os_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (.clk(clk), .rst(rst), .div(div), .tick(tick));

    rx_state_e              state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [SCW-1:0]         sc_q, sc_d;
    logic [DBW-1:0]         bit_cnt_q, bit_cnt_d, nbits_q, nbits_d;
    logic [1:0]             samp_q, samp_d;
    logic [MAX_DATAWIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic stop_cnt_q, stop_cnt_d, par_q, par_d, zero_q, zero_d, perr_q, perr_d, ferr_q, ferr_d;
    logic par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
    logic valid_q, valid_d, perr_o_q, perr_o_d, ferr_o_q, ferr_o_d, ovr_q, ovr_d, brk_q, brk_d;
    logic rx_sync, vote, dec, wrap, ferr_fin, zero_fin, final_stop, done, load;

    always_comb begin
        sync_d     = {sync_q[0], rx};
        rx_sync    = sync_q[1];
        vote       = maj3(samp_q[1], samp_q[0], rx_sync);
        dec        = tick && sc_q == SC_HI;
        wrap       = tick && sc_q == SC_LAST;
        ferr_fin   = ferr_q | ~vote;
        // break pattern covers only the first stop bit, whose vote is folded in here
        zero_fin   = zero_q & (stop_cnt_q | ~vote);
        final_stop = state_q == S_STOP && dec && stop_cnt_q == (stop2_q == STOP_2);
        done       = final_stop && !zero_fin;
        load       = done && (!valid_q || rxo.rx_ready);
    end

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_d      = par_q;
        zero_d     = zero_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        if (tick && state_q != S_IDLE && state_q != S_BREAK) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
            if (sc_q == SC_LO) samp_d[1] = rx_sync;
            if (sc_q == SC_M)  samp_d[0] = rx_sync;
        end
        case (state_q)
            S_IDLE: if (tick && !rx_sync) begin
                state_d    = S_START;
                sc_d       = SCW'(1);
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                shift_d    = '0;
                par_d      = 1'b0;
                zero_d     = 1'b1;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                nbits_d    = (data_bits < NB_MIN) ? NB_MIN : (data_bits > NB_MAX) ? NB_MAX : data_bits;
                par_en_d   = parity_enable;
                par_type_d = parity_type;
                stop2_d    = stop_bits;
            end
            S_START: begin
                if (dec && vote) state_d = S_IDLE;
                else if (wrap)   state_d = S_DATA;
            end
            S_DATA: begin
                if (dec) begin
                    shift_d = shift_q | (MAX_DATAWIDTH'(vote) << bit_cnt_q);
                    par_d   = par_q ^ vote;
                    zero_d  = zero_q & ~vote;
                end
                if (wrap) begin
                    if (bit_cnt_q == nbits_q - 1'b1) state_d = par_en_q ? S_PARITY : S_STOP;
                    else                             bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (dec) begin
                    perr_d = par_q ^ vote ^ (par_type_q == PAR_ODD);
                    zero_d = zero_q & ~vote;
                end
                if (wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (dec) begin
                    ferr_d = ferr_fin;
                    zero_d = zero_fin;
                    if (final_stop) state_d = zero_fin ? S_BREAK : S_IDLE;
                end else if (wrap) begin
                    stop_cnt_d = 1'b1;
                end
            end
            S_BREAK: if (rx_sync) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d  = load | (valid_q & ~rxo.rx_ready);
        data_d   = load ? shift_q : data_q;
        perr_o_d = load ? perr_q : perr_o_q;
        ferr_o_d = load ? ferr_fin : ferr_o_q;
        ovr_d    = done & valid_q & ~rxo.rx_ready;
        brk_d    = final_stop & zero_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            sc_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            par_q      <= 1'b0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            nbits_q    <= NB_MAX;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_o_q   <= 1'b0;
            ferr_o_q   <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            sc_q       <= sc_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stop2_q    <= stop2_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_o_q   <= perr_o_d;
            ferr_o_q   <= ferr_o_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign rxo.rx_data       = data_q;
    assign rxo.rx_valid      = valid_q;
    assign rxo.parity_error  = perr_o_q;
    assign rxo.framing_error = ferr_o_q;
    assign rxo.overrun_error = ovr_q;
    assign rxo.break_detect  = brk_q;
    assign busy              = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench driving serial frames and checking delivered words and events.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] div = '0;
    logic [3:0]  data_bits = 4'd8;
    logic        parity_enable = 1'b0;
    logic        parity_type = PAR_EVEN;
    logic        stop_bits = STOP_1;
    logic        rx = 1'b1;
    logic        busy;
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0, n_brk = 0, n_ovr = 0, n_vcyc = 0, n_push = 0, n_acc = 0;

    uart_rx_cfg_if #(.MAX_DATAWIDTH(8)) rif();

    uart_rx_cfg #(.MAX_DATAWIDTH(8), .OVERSAMPLING(16), .DIV_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .div(div), .data_bits(data_bits), .parity_enable(parity_enable),
        .parity_type(parity_type), .stop_bits(stop_bits), .rx(rx), .rxo(rif.master), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int nb, input logic pe, input logic pt, input logic sbits);
        data_bits     = nb[3:0];
        parity_enable = pe;
        parity_type   = pt;
        stop_bits     = sbits;
    endtask

    // fpar < 0 sends the correct parity bit; glitch >= 0 flips one tick at mid-bit of that data bit
    task automatic frame(input logic [7:0] d, input int fpar, input logic sv, input int glitch, input logic push);
        int nb, bt;
        logic [7:0] mask, dm;
        logic pbit, par;
        exp_t e;
        nb   = (data_bits < 5) ? 5 : (data_bits > 8) ? 8 : int'(data_bits);
        bt   = (int'(div) + 1) * 16;
        mask = 8'((9'h1 << nb) - 1);
        dm   = d & mask;
        par  = ^dm;
        pbit = (fpar < 0) ? par ^ parity_type : fpar[0];
        e.d  = dm;
        e.pe = parity_enable ? (par ^ pbit ^ parity_type) : 1'b0;
        e.fe = ~sv;
        if (push && !(dm == 0 && (!parity_enable || !pbit) && !sv)) begin
            sb.push_back(e);
            n_push++;
        end
        rx = 1'b0;
        wait_clks(bt);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            if (i == glitch) begin
                wait_clks(8);
                rx = ~d[i];
                wait_clks(1);
                rx = d[i];
                wait_clks(7);
            end else begin
                wait_clks(bt);
            end
        end
        if (parity_enable) begin
            rx = pbit;
            wait_clks(bt);
        end
        for (int s = 0; s < (stop_bits ? 2 : 1); s++) begin
            rx = sv;
            wait_clks(bt);
        end
        rx = 1'b1;
        wait_clks(2 * bt);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rif.break_detect) n_brk++;
            if (rif.overrun_error) n_ovr++;
            if (rif.rx_valid) n_vcyc++;
            if (rif.rx_valid && rif.rx_ready) begin
                exp_t e;
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_acc++;
                    chk("rx_data", 32'(rif.rx_data), 32'(e.d));
                    chk("parity_error", 32'(rif.parity_error), 32'(e.pe));
                    chk("framing_error", 32'(rif.framing_error), 32'(e.fe));
                end
            end
        end
    end

    initial begin
        int v0, b0, o0;
        rif.rx_ready = 1'b1;
        wait_clks(3);
        chk("rst_valid", 32'(rif.rx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(rif.rx_data), 0);
        chk("rst_flags", 32'({rif.parity_error, rif.framing_error, rif.overrun_error, rif.break_detect}), 0);
        rst = 1'b0;
        wait_clks(20);

        cfg(8, 1'b0, PAR_EVEN, STOP_1);
        v0 = n_vcyc;
        frame(8'hA5, -1, 1'b1, -1, 1'b1);
        chk("t1_valid_cycles", 32'(n_vcyc - v0), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_drained", 32'(sb.size()), 0);

        cfg(7, 1'b1, PAR_EVEN, STOP_2);
        frame(8'h3C, 1, 1'b1, -1, 1'b1);
        frame(8'h3C, -1, 1'b1, -1, 1'b1);
        cfg(7, 1'b1, PAR_ODD, STOP_2);
        frame(8'h3C, -1, 1'b1, -1, 1'b1);
        frame(8'h3C, 0, 1'b1, -1, 1'b1);
        chk("t2_drained", 32'(sb.size()), 0);

        cfg(8, 1'b0, PAR_EVEN, STOP_1);
        v0 = n_vcyc;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(16);
        chk("t3_glitch_busy", 32'(busy), 0);
        chk("t3_glitch_novalid", 32'(n_vcyc - v0), 0);
        frame(8'h5A, -1, 1'b1, 2, 1'b1);
        frame(8'h5A, -1, 1'b1, 1, 1'b1);

        v0 = n_vcyc;
        b0 = n_brk;
        rx = 1'b0;
        wait_clks(11 * 16);
        chk("t4_busy_in_break", 32'(busy), 1);
        wait_clks(16);
        rx = 1'b1;
        wait_clks(4);
        chk("t4_busy_after", 32'(busy), 0);
        chk("t4_break_pulses", 32'(n_brk - b0), 1);
        chk("t4_novalid", 32'(n_vcyc - v0), 0);
        frame(8'h55, -1, 1'b1, -1, 1'b1);

        o0 = n_ovr;
        rif.rx_ready = 1'b0;
        frame(8'h11, -1, 1'b1, -1, 1'b1);
        frame(8'h22, -1, 1'b1, -1, 1'b0);
        chk("t5_valid_held", 32'(rif.rx_valid), 1);
        chk("t5_data_kept", 32'(rif.rx_data), 32'h11);
        chk("t5_overrun", 32'(n_ovr - o0), 1);
        rif.rx_ready = 1'b1;
        wait_clks(1);
        chk("t5_valid_drop", 32'(rif.rx_valid), 0);
        chk("t5_drained", 32'(sb.size()), 0);

        cfg(5, 1'b0, PAR_EVEN, STOP_1);
        frame(8'hFB, -1, 1'b0, -1, 1'b1);
        cfg(2, 1'b0, PAR_EVEN, STOP_1);
        frame(8'hEE, -1, 1'b1, -1, 1'b1);
        cfg(15, 1'b0, PAR_EVEN, STOP_1);
        frame(8'hC3, -1, 1'b1, -1, 1'b1);

        cfg(8, 1'b0, PAR_EVEN, STOP_1);
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(16);
        rx = 1'b0;
        wait_clks(8);
        rst = 1'b1;
        wait_clks(2);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_valid", 32'(rif.rx_valid), 0);
        chk("t6_rst_outs", 32'({rif.rx_data, rif.parity_error, rif.framing_error, rif.overrun_error, rif.break_detect}), 0);
        rst = 1'b0;
        rx = 1'b1;
        wait_clks(32);
        frame(8'h5A, -1, 1'b1, -1, 1'b1);

        div = 12'd2;
        cfg(8, 1'b1, PAR_ODD, STOP_1);
        frame(8'h96, -1, 1'b1, -1, 1'b1);
        frame(8'h96, 0, 1'b1, -1, 1'b1);

        wait_clks(20);
        chk("end_drained", 32'(sb.size()), 0);
        chk("end_words", 32'(n_acc), 32'(n_push));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
